// File: rtl/core_lsu.sv
// core_lsu: load/store unit fed by the execute-stage ALU sum.
// Accepts one load/store at a time, runs a req/gnt/rvalid handshake on the
// data bus, builds byte enables and lane-replicated store data, extracts and
// extends load data, and returns one response pulse per accepted operation.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o execute-stage request handshake (ready only in IDLE)
//   is_store_i          1 = store, 0 = load
//   funct3_i            RV32I width/sign field
//   addr_i, wdata_i     effective address, store data (rs2)
//   resp_valid_o        one-cycle completion pulse
//   rdata_o, error_o    load result and error flag, held until next response
//   mem_*_o             data bus request, write enable, byte enables,
//                       word address, store data
//   mem_gnt_i           bus accepted the request
//   mem_rvalid_i        read data / write acknowledge
//   mem_rdata_i         read data word
module core_lsu (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] rdata_o,
  output logic        error_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state_q;
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        req_err;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_ext;
  logic        in_req;

  assign accept = req_valid_i && req_ready_o;

  // Decode of the incoming request: width from funct3[1:0], alignment
  // against addr[1:0]. Loads 6/7 and stores 4..7 are unsupported.
  always_comb begin
    req_err   = 1'b0;
    req_be    = '0;
    req_wdata = wdata_i;
    case (funct3_i[1:0])
      2'd0: begin
        req_be    = 4'b0001 << addr_i[1:0];
        req_wdata = {4{wdata_i[7:0]}};
      end
      2'd1: begin
        req_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{wdata_i[15:0]}};
        req_err   = addr_i[0];
      end
      2'd2: begin
        req_be  = 4'b1111;
        req_err = |addr_i[1:0];
      end
      default: begin
        req_be  = '0;
        req_err = 1'b1;
      end
    endcase
    if (funct3_i[2] && (is_store_i || funct3_i[1])) begin
      req_err = 1'b1;
    end
  end

  // Lane selection and extension of the returned read word.
  always_comb begin
    ld_byte = mem_rdata_i[7:0];
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_ext = {{16{ld_half[15]}}, ld_half};
      3'd4:    load_ext = {24'd0, ld_byte};
      3'd5:    load_ext = {16'd0, ld_half};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= '0;
      off_q      <= '0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            off_q      <= addr_i[1:0];
            be_q       <= req_be;
            addr_q     <= {addr_i[31:2], 2'b00};
            wdata_q    <= req_wdata;
            if (req_err) begin
              // Erroring accesses skip the bus and respond next cycle.
              rdata_q <= '0;
              error_q <= 1'b1;
              state_q <= S_RESP;
            end else begin
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            error_q <= 1'b0;
            if (!is_store_q) begin
              rdata_q <= load_ext;
            end
            state_q <= S_RESP;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_req       = (state_q == S_REQ);
  assign req_ready_o  = (state_q == S_IDLE);
  assign resp_valid_o = (state_q == S_RESP);
  assign rdata_o      = rdata_q;
  assign error_o      = error_q;
  assign mem_req_o    = in_req;
  assign mem_we_o     = in_req && is_store_q;
  assign mem_be_o     = in_req ? be_q    : '0;
  assign mem_addr_o   = in_req ? addr_q  : '0;
  assign mem_wdata_o  = in_req ? wdata_q : '0;

endmodule
